// File: rtl/cbus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cbus_rr_arbiter
//
// Round-robin arbiter that shares one CBus master port between NUM_INPUTS
// requesters. The winning request is latched and held on oreq until the
// downstream burst ends with oresp.last. Responses are steered only to the
// owner. After each completed transaction, priority rotates to owner+1.
// Every transaction is followed by one IDLE cycle (arbitration bubble).
//
// Packed bus layouts:
//   request  (REQ_W bits) : bit 0 = valid, bits [REQ_W-1:1] = opaque fields
//   response (RESP_W bits): bit 0 = ready, bit 1 = last,
//                           bits [RESP_W-1:2] = data
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   ireqs        NUM_INPUTS packed requests; requester i occupies
//                bits [i*REQ_W +: REQ_W]
//   iresps       NUM_INPUTS packed responses, same slicing with RESP_W
//   oreq         registered shared downstream request
//   oresp        shared downstream response
//   grant_id     current (or most recent) owner index
//   busy         a transaction is in flight
//   timeout_err  sticky watchdog error flag
//
// Optional feature macro: CBUS_ARB_TIMEOUT_EN
//   When defined, a watchdog forces a ready/last/zero-data response to the
//   owner after TIMEOUT_CYCLES BUSY cycles without oresp.ready, completes
//   the transaction and sets timeout_err. When undefined, timeout_err is 0.
// ---------------------------------------------------------------------------
module cbus_rr_arbiter #(
    parameter int NUM_INPUTS     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int REQ_W          = 40,
    parameter int DATA_W         = 32,
    localparam int RESP_W        = DATA_W + 2,
    localparam int IW            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_INPUTS*REQ_W-1:0]  ireqs,
    output logic [NUM_INPUTS*RESP_W-1:0] iresps,
    output logic [REQ_W-1:0]             oreq,
    input  logic [RESP_W-1:0]            oresp,
    output logic [IW-1:0]                grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    if (NUM_INPUTS < 1 || NUM_INPUTS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cbus_rr_arbiter: NUM_INPUTS must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [REQ_W-1:0]  saved_req_q, saved_req_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    int                scan_idx;
    logic [RESP_W-1:0] resp_eff;
    logic              done;
    logic              timeout_hit;

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Rotating scan: offset k from rr_ptr, wrapped into 0..NUM_INPUTS-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_INPUTS) begin
                scan_idx = scan_idx - NUM_INPUTS;
            end
            if (!win_found && ireqs[scan_idx*REQ_W]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        saved_req_d = saved_req_q;
        iresps      = '0;
        timeout_hit = 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        timeout_hit   = (state_q == BUSY) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif
        // A watchdog expiry replaces the downstream response for one cycle.
        resp_eff = timeout_hit ? RESP_W'(2'b11) : oresp;
        done     = timeout_hit | oresp[1];

        case (state_q)
            IDLE: begin
`ifdef CBUS_ARB_TIMEOUT_EN
                wd_d = '0;
`endif
                if (win_found) begin
                    owner_d     = win_idx;
                    saved_req_d = ireqs[int'(win_idx)*REQ_W +: REQ_W];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                iresps[int'(owner_q)*RESP_W +: RESP_W] = resp_eff;
`ifdef CBUS_ARB_TIMEOUT_EN
                if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                end else if (oresp[0]) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
                if (done) begin
                    state_d     = IDLE;
                    saved_req_d = '0;
                    rr_ptr_d    = (int'(owner_q) == NUM_INPUTS - 1) ? '0 : owner_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            saved_req_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            saved_req_q <= saved_req_d;
        end
    end

`ifdef CBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign oreq     = saved_req_q;
    assign busy     = (state_q == BUSY);
    assign grant_id = owner_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;

    localparam int N      = 3;
    localparam int REQ_W  = 40;
    localparam int DATA_W = 32;
    localparam int RESP_W = DATA_W + 2;
    localparam int IW     = 2;
`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int TO     = 8;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO     = 1024;
    localparam bit TO_EN  = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N*REQ_W-1:0]    ireqs;
    logic [N*RESP_W-1:0]   iresps;
    logic [REQ_W-1:0]      oreq;
    logic [RESP_W-1:0]     oresp;
    logic [IW-1:0]         grant_id;
    logic                  busy;
    logic                  timeout_err;

    always #5 clk = ~clk;

    cbus_rr_arbiter #(
        .NUM_INPUTS     (N),
        .TIMEOUT_CYCLES (TO),
        .REQ_W          (REQ_W),
        .DATA_W         (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ireqs       (ireqs),
        .iresps      (iresps),
        .oreq        (oreq),
        .oresp       (oresp),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [REQ_W-1:0]    oreq;
        logic [N*RESP_W-1:0] iresps;
        logic                busy;
        logic [IW-1:0]       gid;
        logic                terr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: arbitration follows a rotation list of requester
    // indices; the head of the list has highest priority.
    bit               m_busy;
    int               m_owner;
    int               m_order[$];
    logic [REQ_W-1:0] m_saved;
    int               m_beat, m_len, m_wd;
    bit               m_terr, m_stall;
    bit               r_act[N];
    logic [REQ_W-1:0] r_pay[N];
    int               r_len[N];
    int               resets_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("oreq", 64'(oreq), 64'(mon_e.oreq));
            for (int i = 0; i < N; i++) begin
                check($sformatf("iresps[%0d]", i), 64'(iresps[i*RESP_W +: RESP_W]),
                      64'(mon_e.iresps[i*RESP_W +: RESP_W]));
            end
            check("busy", 64'(busy), 64'(mon_e.busy));
            check("grant_id", 64'(grant_id), 64'(mon_e.gid));
            check("timeout_err", 64'(timeout_err), 64'(mon_e.terr));
        end
    end

    function automatic logic [REQ_W-1:0] rand_payload(input bit valid);
        logic [REQ_W-1:0] p;
        p[31:0]       = $urandom;
        p[REQ_W-1:32] = 8'($urandom);
        p[0]          = valid;
        return p;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_order = {};
        for (int i = 0; i < N; i++) begin
            m_order.push_back(i);
            r_act[i] = 1'b0;
        end
        m_saved = '0;
        m_terr  = 1'b0;
        m_wd    = 0;
        m_beat  = 0;
        m_len   = 0;
        m_stall = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_oreq", 64'(oreq), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_iresps[%0d]", i), 64'(iresps[i*RESP_W +: RESP_W]), 64'd0);
        end
    endtask

    task automatic do_cycle();
        logic [RESP_W-1:0] o;
        exp_t              e;
        bit                to_hit, fin, rdy;
        int                j;

        for (int i = 0; i < N; i++) begin
            if (!r_act[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    r_act[i] = 1'b1;
                    r_pay[i] = rand_payload(1'b1);
                    r_len[i] = int'($urandom_range(1, 4));
                end else begin
                    r_pay[i] = rand_payload(1'b0);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // Field churn on an active requester; the latched copy must not follow.
                r_pay[i] = rand_payload(1'b1);
            end
            ireqs[i*REQ_W +: REQ_W] = r_pay[i];
        end

        o[RESP_W-1:2] = $urandom;
        o[1:0]        = 2'($urandom);
        if (m_busy) begin
            rdy  = m_stall ? 1'b0 : ($urandom_range(0, 9) < 7);
            o[0] = rdy;
            o[1] = rdy && (m_beat + 1 == m_len);
        end
        oresp = o;

        to_hit   = TO_EN && m_busy && (m_wd == TO - 1);
        e.oreq   = m_saved;
        e.busy   = m_busy;
        e.gid    = IW'(m_owner);
        e.terr   = m_terr;
        e.iresps = '0;
        if (m_busy) begin
            e.iresps[m_owner*RESP_W +: RESP_W] = to_hit ? RESP_W'(3) : o;
        end
        sb.push_back(e);

        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                j = m_order[k];
                if (!m_busy && r_act[j]) begin
                    m_busy  = 1'b1;
                    m_owner = j;
                    m_saved = r_pay[j];
                    m_beat  = 0;
                    m_len   = r_len[j];
                    m_wd    = 0;
                    m_stall = TO_EN && ($urandom_range(0, 5) == 0);
                end
            end
        end else begin
            if (to_hit) begin
                m_terr = 1'b1;
                fin    = 1'b1;
            end else begin
                fin = o[1];
                if (o[0]) begin
                    m_beat++;
                    m_wd = 0;
                end else begin
                    m_wd++;
                end
            end
            if (fin) begin
                m_busy         = 1'b0;
                m_saved        = '0;
                r_act[m_owner] = 1'b0;
                while (m_order[0] != (m_owner + 1) % N) begin
                    m_order.push_back(m_order.pop_front());
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        resets_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (m_busy && m_beat == 1 && resets_done < 2 && c > 200 * (resets_done + 1)) begin
                // Asynchronous reset in the middle of a burst.
                reset = 1'b1;
                #1;
                check_reset_outputs();
                @(posedge clk);
                #1;
                reset = 1'b0;
                model_reset();
                resets_done++;
            end
            do_cycle();
        end

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
